// File: rtl/vga_rect_compositor_pkg.sv
// Shared types for the rectangle compositor: coordinate width, rectangle
// geometry record, commit FSM states and the half-open span test.
package vga_rect_compositor_pkg;

  localparam int COORD_W = 10;
  localparam int SUM_W   = COORD_W + 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   en;
    coord_t h;
    coord_t w;
    coord_t y;
    coord_t x;
  } rect_geom_t;

  typedef enum logic {ST_IDLE, ST_COMMIT} commit_st_t;

  // base + len is formed one bit wider so a rect near 1023 cannot wrap.
  function automatic logic in_span(input coord_t p, input coord_t base, input coord_t len);
    logic [SUM_W-1:0] w_lo, w_hi, w_p;
    w_lo = SUM_W'(base);
    w_hi = SUM_W'(base) + SUM_W'(len);
    w_p  = SUM_W'(p);
    return (w_p >= w_lo) && (w_p < w_hi);
  endfunction

endpackage

// File: rtl/vga_rect_compositor_hit.sv
// Per-rectangle hit test against the active geometry; registered as the
// S1 hit bit for this rectangle.
module vga_rect_hit
  import vga_rect_compositor_pkg::*;
(
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  coord_t     i_x,
  input  coord_t     i_y,
  input  rect_geom_t i_rect,
  output logic       o_hit
);

  logic w_hit;
  logic r_hit;

  assign w_hit = i_rect.en && in_span(i_x, i_rect.x, i_rect.w) && in_span(i_y, i_rect.y, i_rect.h);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) r_hit <= 1'b0;
    else          r_hit <= w_hit;
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/vga_rect_compositor.sv
// Composites NUM_RECTS solid rectangles over a background colour. Software
// writes a shadow set; it is copied to the active set once per frame at vSync.
module vga_rect_compositor
  import vga_rect_compositor_pkg::*;
#(
  parameter int              NUM_RECTS    = 4,
  parameter int              CW           = 3,
  parameter int              H_ACTIVE     = 640,
  parameter int              V_ACTIVE     = 480,
  parameter logic [3*CW-1:0] BG_COLOR     = '0,
  parameter bit              SYNC_ACT_LOW = 1'b1
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  input  logic            i_hSync,
  input  logic            i_vSync,
  input  logic [9:0]      i_display_x_pos,
  input  logic [9:0]      i_display_y_pos,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [3:0]      i_wr_idx,
  input  logic [9:0]      i_wr_x,
  input  logic [9:0]      i_wr_y,
  input  logic [9:0]      i_wr_w,
  input  logic [9:0]      i_wr_h,
  input  logic [3*CW-1:0] i_wr_color,
  input  logic            i_wr_en,
  output logic [CW-1:0]   o_red,
  output logic [CW-1:0]   o_green,
  output logic [CW-1:0]   o_blue,
  output logic            o_hSync,
  output logic            o_vSync,
  output logic            o_frame_commit
);

  localparam int               COL_W     = 3 * CW;
  localparam logic             SYNC_IDLE = logic'(SYNC_ACT_LOW);
  localparam logic [SUM_W-1:0] H_LIM     = SUM_W'(H_ACTIVE);
  localparam logic [SUM_W-1:0] V_LIM     = SUM_W'(V_ACTIVE);

  commit_st_t r_state, w_state_nxt;
  logic       r_vs_prev;
  logic       w_vs_edge;
  logic       w_wr_fire;

  rect_geom_t       r_sh_geo  [NUM_RECTS];
  rect_geom_t       r_act_geo [NUM_RECTS];
  logic [COL_W-1:0] r_sh_col  [NUM_RECTS];
  logic [COL_W-1:0] r_act_col [NUM_RECTS];

  logic [NUM_RECTS-1:0] w_hit_s1;
  logic                 r_onscr_s1;
  logic [COL_W-1:0]     w_col_s2;
  logic [COL_W-1:0]     r_rgb;
  logic [1:0]           r_hs_pipe, r_vs_pipe;

  // ---------------- commit FSM ----------------
  assign w_vs_edge = SYNC_ACT_LOW ? (r_vs_prev && !i_vSync) : (!r_vs_prev && i_vSync);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state   <= ST_IDLE;
      r_vs_prev <= SYNC_IDLE;
    end else begin
      r_state   <= w_state_nxt;
      r_vs_prev <= i_vSync;
    end
  end

  always_comb begin
    w_state_nxt    = ST_IDLE;
    o_frame_commit = 1'b0;
    o_wr_ready     = 1'b1;
    case (r_state)
      ST_IDLE:   if (w_vs_edge) w_state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        // Writes stall for the copy cycle so none straddles the frame swap.
        o_frame_commit = 1'b1;
        o_wr_ready     = 1'b0;
        if (w_vs_edge) w_state_nxt = ST_COMMIT;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr_fire = i_wr_valid && o_wr_ready;

  // ---------------- shadow / active register sets ----------------
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        r_sh_geo[i]  <= '0;
        r_act_geo[i] <= '0;
        r_sh_col[i]  <= '0;
        r_act_col[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (w_wr_fire && (i_wr_idx == 4'(i))) begin
          r_sh_geo[i] <= '{en: i_wr_en, h: i_wr_h, w: i_wr_w, y: i_wr_y, x: i_wr_x};
          r_sh_col[i] <= i_wr_color;
        end
        if (o_frame_commit) begin
          r_act_geo[i] <= r_sh_geo[i];
          r_act_col[i] <= r_sh_col[i];
        end
      end
    end
  end

  // ---------------- S1: per-rect hit + on-screen flag ----------------
  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_rect
    vga_rect_hit u_hit (
      .i_CLK  (i_CLK),
      .i_RST_N(i_RST_N),
      .i_x    (i_display_x_pos),
      .i_y    (i_display_y_pos),
      .i_rect (r_act_geo[g]),
      .o_hit  (w_hit_s1[g])
    );
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) r_onscr_s1 <= 1'b0;
    else          r_onscr_s1 <= (SUM_W'(i_display_x_pos) < H_LIM) && (SUM_W'(i_display_y_pos) < V_LIM);
  end

  // ---------------- S2: priority select, lowest index wins ----------------
  always_comb begin
    w_col_s2 = BG_COLOR;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (w_hit_s1[i]) w_col_s2 = r_act_col[i];
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_rgb     <= '0;
      r_hs_pipe <= {2{SYNC_IDLE}};
      r_vs_pipe <= {2{SYNC_IDLE}};
    end else begin
      r_rgb     <= r_onscr_s1 ? w_col_s2 : '0;
      r_hs_pipe <= {r_hs_pipe[0], i_hSync};
      r_vs_pipe <= {r_vs_pipe[0], i_vSync};
    end
  end

  assign o_red   = r_rgb[3*CW-1:2*CW];
  assign o_green = r_rgb[2*CW-1:CW];
  assign o_blue  = r_rgb[CW-1:0];
  assign o_hSync = r_hs_pipe[1];
  assign o_vSync = r_vs_pipe[1];

endmodule

// File: tb/tb_vga_rect_compositor.sv
// Bench for vga_rect_compositor: directed probe tables plus a random sweep,
// all checked every cycle against a frame-level reference model.
module tb_vga_rect_compositor;

  localparam logic [8:0] BG    = 9'h053;
  localparam logic [8:0] WHITE = 9'h1FF;
  localparam logic [8:0] RED   = 9'h1C0;
  localparam logic [8:0] GREEN = 9'h038;
  localparam logic [8:0] BLUE  = 9'h007;
  localparam int         NR    = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1;
  logic [9:0] xp = '0, yp = '0;
  logic       wv = 1'b0, wen = 1'b0;
  logic       wrdy;
  logic [3:0] widx = '0;
  logic [9:0] wx = '0, wy = '0, ww = '0, wh = '0;
  logic [8:0] wcol = '0;
  logic [2:0] ored, ogrn, oblu;
  logic       ohs, ovs, ocommit;

  vga_rect_compositor #(.NUM_RECTS(NR), .CW(3), .H_ACTIVE(640), .V_ACTIVE(480),
                        .BG_COLOR(BG), .SYNC_ACT_LOW(1'b1)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_hSync(hs), .i_vSync(vs),
    .i_display_x_pos(xp), .i_display_y_pos(yp),
    .i_wr_valid(wv), .o_wr_ready(wrdy), .i_wr_idx(widx),
    .i_wr_x(wx), .i_wr_y(wy), .i_wr_w(ww), .i_wr_h(wh),
    .i_wr_color(wcol), .i_wr_en(wen),
    .o_red(ored), .o_green(ogrn), .o_blue(oblu),
    .o_hSync(ohs), .o_vSync(ovs), .o_frame_commit(ocommit));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int x, y, w, h, col; bit en; } mrect_t;
  typedef struct { logic [8:0] rgb; logic hs, vs; } mpix_t;
  typedef struct { int x, y; logic [8:0] rgb; } vec_t;

  mrect_t m_sh[NR], m_act[NR];
  bit     m_vprev, m_commit;
  mpix_t  m_p1, m_out;
  int     checks = 0, errors = 0;
  vec_t   tv[$];

  function automatic logic [8:0] ref_pix(int x, int y);
    if (x >= 640 || y >= 480) return 9'h0;
    for (int i = 0; i < NR; i++)
      if (m_act[i].en && x >= m_act[i].x && x < m_act[i].x + m_act[i].w &&
          y >= m_act[i].y && y < m_act[i].y + m_act[i].h)
        return m_act[i].col[8:0];
    return BG;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_sh[i]  = '{default: 0};
      m_act[i] = '{default: 0};
    end
    m_vprev = 1'b1; m_commit = 1'b0;
    m_p1 = '{rgb: 9'h0, hs: 1'b1, vs: 1'b1};
    m_out = m_p1;
  endtask

  // One clock edge: a frame swap the cycle after vSync falls, writes blocked that cycle.
  task automatic model_step();
    mpix_t nw;
    nw.rgb = ref_pix(int'(xp), int'(yp)); nw.hs = hs; nw.vs = vs;
    m_out = m_p1; m_p1 = nw;
    if (wv && !m_commit && int'(widx) < NR)
      m_sh[int'(widx)] = '{x: int'(wx), y: int'(wy), w: int'(ww), h: int'(wh), col: int'(wcol), en: wen};
    if (m_commit) m_act = m_sh;
    m_commit = m_vprev && !vs;
    m_vprev  = vs;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rgb",    {23'b0, ored, ogrn, oblu}, {23'b0, m_out.rgb});
    chk("hsync",  {31'b0, ohs},     {31'b0, m_out.hs});
    chk("vsync",  {31'b0, ovs},     {31'b0, m_out.vs});
    chk("commit", {31'b0, ocommit}, {31'b0, m_commit});
    chk("ready",  {31'b0, wrdy},    {31'b0, !m_commit});
  endtask

  task automatic tick();
    @(posedge clk); model_step(); @(negedge clk); check_all();
  endtask

  task automatic set_pos(input int x, input int y);
    xp = 10'(x); yp = 10'(y);
  endtask

  task automatic probe(input string nm, input int x, input int y, input logic [8:0] exp);
    set_pos(x, y); tick(); tick();
    chk(nm, {23'b0, ored, ogrn, oblu}, {23'b0, exp});
  endtask

  task automatic run_tv(input string nm);
    foreach (tv[i]) probe(nm, tv[i].x, tv[i].y, tv[i].rgb);
    tv.delete();
  endtask

  task automatic wr(input int idx, x, y, w, h, col, input bit en, output int tries);
    bit acc;
    widx = 4'(idx); wx = 10'(x); wy = 10'(y); ww = 10'(w); wh = 10'(h);
    wcol = 9'(col); wen = en; wv = 1'b1;
    acc = 1'b0; tries = 0;
    for (int k = 0; k < 10 && !acc; k++) begin
      acc = wrdy; tick(); tries++;
    end
    chk("wr_accept", {31'b0, acc}, 32'd1);
    wv = 1'b0;
  endtask

  task automatic commit_frame();
    int cnt;
    cnt = 0;
    set_pos(700, 490); vs = 1'b0;
    repeat (3) begin tick(); if (ocommit) cnt++; end
    vs = 1'b1; tick();
    chk("commit_pulses", cnt, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); set_pos(300, 100); hs = 1'b1; vs = 1'b1; wv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rgb",    {23'b0, ored, ogrn, oblu}, 32'd0);
    chk("rst_hs",     {31'b0, ohs},     32'd1);
    chk("rst_vs",     {31'b0, ovs},     32'd1);
    chk("rst_commit", {31'b0, ocommit}, 32'd0);
    chk("rst_ready",  {31'b0, wrdy},    32'd1);
    model_reset();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    tick(); chk("post_rst_rgb0", {23'b0, ored, ogrn, oblu}, 32'd0);
    tick(); chk("post_rst_bg",   {23'b0, ored, ogrn, oblu}, {23'b0, BG});
  endtask

  initial begin
    int n;
    model_reset();
    do_reset();

    // Write before any vSync edge: shadow only, screen stays background.
    wr(0, 10, 20, 15, 100, WHITE, 1'b1, n);
    probe("pre_commit_bg", 10, 20, BG);
    commit_frame();
    tv.push_back('{10, 20, WHITE});  tv.push_back('{25, 20, BG});
    tv.push_back('{24, 20, WHITE});  tv.push_back('{10, 119, WHITE});
    tv.push_back('{10, 120, BG});    tv.push_back('{9, 20, BG});
    run_tv("rect0");

    // Overlap, with idx0 rewritten twice before the commit.
    wr(1, 0, 0, 50, 50, RED, 1'b1, n);
    wr(0, 200, 200, 5, 5, BLUE, 1'b1, n);
    wr(0, 40, 40, 20, 20, GREEN, 1'b1, n);
    commit_frame();
    tv.push_back('{45, 45, GREEN}); tv.push_back('{30, 30, RED});
    tv.push_back('{59, 59, GREEN}); tv.push_back('{0, 0, RED});
    tv.push_back('{60, 60, BG});    tv.push_back('{202, 202, BG});
    run_tv("overlap");

    // Exact 2-clock latency of the pixel path.
    set_pos(300, 300); tick(); tick();
    set_pos(45, 45); tick();
    chk("lat_1clk", {23'b0, ored, ogrn, oblu}, {23'b0, BG});
    tick();
    chk("lat_2clk", {23'b0, ored, ogrn, oblu}, {23'b0, GREEN});

    // Write issued during the commit cycle waits one cycle and lands in the next frame.
    set_pos(700, 490); vs = 1'b0; tick();
    chk("commit_cycle", {31'b0, ocommit}, 32'd1);
    wr(2, 100, 100, 10, 10, BLUE, 1'b1, n);
    chk("wr_on_commit_tries", n, 32'd2);
    vs = 1'b1; tick();
    probe("late_wr_hidden", 105, 105, BG);
    commit_frame();
    probe("late_wr_shown", 105, 105, BLUE);

    // Clipping at the screen edge, zero width, out-of-range index.
    wr(3, 630, 470, 100, 20, WHITE, 1'b1, n);
    commit_frame();
    tv.push_back('{639, 479, WHITE}); tv.push_back('{640, 479, 9'h0});
    tv.push_back('{630, 470, WHITE}); tv.push_back('{629, 479, BG});
    tv.push_back('{639, 480, 9'h0});
    run_tv("clip");
    wr(3, 0, 0, 0, 480, WHITE, 1'b1, n);
    wr(15, 0, 0, 640, 480, WHITE, 1'b1, n);
    commit_frame();
    tv.push_back('{0, 300, BG}); tv.push_back('{300, 300, BG});
    tv.push_back('{0, 0, RED});  tv.push_back('{105, 105, BLUE});
    run_tv("w0_idx15");

    // Mid-line reset clears everything back to background.
    do_reset();
    probe("reset_cleared", 10, 20, BG);

    // Random frames: random rect sets, then random pixel/hSync sweep.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 6; k++)
        wr($urandom_range(0, 5), $urandom_range(0, 700), $urandom_range(0, 520),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 250),
           $urandom_range(0, 250), $urandom_range(0, 511), ($urandom_range(0, 3) != 0), n);
      commit_frame();
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 9) == 0) set_pos($urandom_range(0, 1023), $urandom_range(0, 1023));
        else                           set_pos($urandom_range(0, 700), $urandom_range(0, 520));
        hs = 1'($urandom_range(0, 1));
        tick();
      end
      hs = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
